cic_decimator_mc: RTL and testbench

- Multi-channel CIC decimator, successor to the single-channel fixed-rate downsampler.
- CH parallel lanes share one input valid.
- Decimation rate is a power of two selectable at run time; the block generates its own decimation strobe from an internal counter (no external output enable).
- Gain is normalised by shift with round-half-up and saturation; output uses a valid/ready handshake with a sticky overrun flag.
- Sits between the ADC front-end sample stream and downstream FIR/compensation filters.

---
 rtl/cic_pkg.sv | 43 ++++
 rtl/cic_mc_lane.sv | 79 +++++++
 rtl/cic_decimator_mc.sv | 99 +++++++++
 tb/tb_cic_decimator_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the multi-channel CIC decimator: width sizing, rate clamp, output scaling.
// Pure functions and constants only; no latency of its own.
// No flow control; used by the datapath modules at elaboration and in combinational logic.
package cic_pkg;

  // Width of the scratch value used for rounding/saturation; wide enough for any legal DW plus headroom.
  localparam int PW = 128;

  // log2 of the differential delay (M is restricted to 1 or 2).
  function automatic int lm_of(input int m);
    return (m == 2) ? 1 : 0;
  endfunction

  // Internal datapath width: input width plus worst-case CIC bit growth.
  function automatic int dw_calc(input int w, input int n, input int rlog2_max, input int m);
    return w + n * (rlog2_max + lm_of(m));
  endfunction

  // Clamp a requested log2 rate into 1..vmax.
  function automatic int clamp_rate(input int v, input int vmax);
    if (v < 1) return 1;
    if (v > vmax) return vmax;
    return v;
  endfunction

  // Arithmetic right shift with optional round-half-up, then saturate to an ow-bit signed range.
  function automatic logic signed [PW-1:0] sat_round(input logic signed [PW-1:0] value,
                                                     input int shift, input int ow,
                                                     input logic rnd);
    logic signed [PW-1:0] t;
    logic signed [PW-1:0] vmax;
    logic signed [PW-1:0] vmin;
    t = value;
    if (rnd && (shift > 0)) t = t + (PW'(1) <<< (shift - 1));
    t    = t >>> shift;
    vmax = (PW'(1) <<< (ow - 1)) - PW'(1);
    vmin = -(PW'(1) <<< (ow - 1));
    if (t > vmax) t = vmax;
    else if (t < vmin) t = vmin;
    return t;
  endfunction

endpackage

// File: rtl/cic_mc_lane.sv
// One CIC channel: N integrators at input rate, N combs at decimated rate, shift/round/saturate.
// Combinational output y is valid in the decimation-beat cycle; the top registers it (1 clk total).
// No backpressure: integrators advance on every input beat, combs on every decimation beat.
module cic_mc_lane
  import cic_pkg::*;
#(
  parameter int W         = 16,
  parameter int OW        = 16,
  parameter int N         = 3,
  parameter int M         = 1,
  parameter int RLOG2_MAX = 6,
  parameter int RW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_vld,
  input  logic          dec,
  input  logic [W-1:0]  in_data,
  input  logic [RW-1:0] rate_log2,
  output logic [OW-1:0] y
);

  localparam int DW = dw_calc(W, N, RLOG2_MAX, M);
  localparam int LM = lm_of(M);
`ifdef CIC_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic signed [DW-1:0] w_in_ext;
  logic signed [DW-1:0] r_acc  [1:N];
  logic signed [DW-1:0] w_next [1:N];
  logic signed [DW-1:0] r_dly  [1:N][0:M-1];
  logic signed [DW-1:0] w_c    [0:N];
  int                   w_shift;

  assign w_in_ext = DW'(signed'(in_data));

  // Integrator next values and comb chain; wrap-around in the integrators cancels in the combs.
  always_comb begin
    w_next[1] = r_acc[1] + w_in_ext;
    for (int k = 2; k <= N; k++) begin
      w_next[k] = r_acc[k] + r_acc[k-1];
    end
    w_c[0] = w_next[N];
    for (int k = 1; k <= N; k++) begin
      w_c[k] = w_c[k-1] - r_dly[k][M-1];
    end
  end

  // Integrators advance on input beats; comb delay lines shift on decimation beats.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 1; k <= N; k++) begin
        r_acc[k] <= '0;
        for (int j = 0; j < M; j++) r_dly[k][j] <= '0;
      end
    end else begin
      if (in_vld) begin
        for (int k = 1; k <= N; k++) r_acc[k] <= w_next[k];
      end
      if (dec) begin
        for (int k = 1; k <= N; k++) begin
          r_dly[k][0] <= w_c[k-1];
          for (int j = 1; j < M; j++) r_dly[k][j] <= r_dly[k][j-1];
        end
      end
    end
  end

  // Normalise the R^N*M^N gain by a shift, then clip to the output width.
  always_comb begin
    w_shift = N * (int'(rate_log2) + LM);
    y       = OW'(sat_round(PW'(w_c[N]), w_shift, OW, RND));
  end

endmodule

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator, run-time power-of-two rate; CIC_ROUND_EN selects round-half-up vs truncate.
// Latency: output registered one clk after the decimation beat.
// Backpressure: valid/ready output; an unaccepted sample is overwritten and sets the sticky ovf flag.
module cic_decimator_mc
  import cic_pkg::*;
#(
  parameter int W         = 16,
  parameter int OW        = 16,
  parameter int CH        = 4,
  parameter int N         = 3,
  parameter int M         = 1,
  parameter int RLOG2_MAX = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_load,
  input  logic [$clog2(RLOG2_MAX+1)-1:0]   cfg_rate_log2,
  input  logic                             in_valid,
  input  logic [CH*W-1:0]                  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CH*OW-1:0]                 out_data,
  output logic                             ovf
);

  localparam int RW = $clog2(RLOG2_MAX + 1);

  logic [RW-1:0]        r_rate;
  logic [RLOG2_MAX-1:0] r_cnt;
  logic [RLOG2_MAX-1:0] w_cnt_max;
  logic                 w_dec;
  logic [CH*OW-1:0]     w_lane_y;

  // R-1 as a mask of rate_log2 low ones; a beat in the same cycle as cfg_load is discarded.
  always_comb begin
    w_cnt_max = '0;
    for (int i = 0; i < RLOG2_MAX; i++) begin
      w_cnt_max[i] = (i < int'(r_rate));
    end
    w_dec = in_valid && !cfg_load && (r_cnt == w_cnt_max);
  end

  // Rate register: resets to R=2, loads a clamped value on cfg_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate <= RW'(1);
    end else if (cfg_load) begin
      r_rate <= RW'(clamp_rate(int'(cfg_rate_log2), RLOG2_MAX));
    end
  end

  // Decimation counter: 0..R-1 over input beats, restarts on cfg_load.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_dec ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    cic_mc_lane #(
      .W         (W),
      .OW        (OW),
      .N         (N),
      .M         (M),
      .RLOG2_MAX (RLOG2_MAX),
      .RW        (RW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (cfg_load),
      .in_vld    (in_valid),
      .dec       (w_dec),
      .in_data   (in_data[c*W +: W]),
      .rate_log2 (r_rate),
      .y         (w_lane_y[c*OW +: OW])
    );
  end

  // Output register and handshake; a load while a sample is still unaccepted is an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else if (cfg_load) begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (w_dec) begin
      out_data  <= w_lane_y;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) ovf <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed bench for cic_decimator_mc with hand-computed expected samples.
// Main instance uses defaults (N=3, M=1); a second N=1 instance exercises rounding.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cic_decimator_mc;

  localparam int W  = 16;
  localparam int OW = 16;
  localparam int CH = 4;
`ifdef CIC_ROUND_EN
  localparam int RND_EXP = 1;
`else
  localparam int RND_EXP = 0;
`endif

  logic              clk;
  logic              rst;
  logic              cfg_load;
  logic [2:0]        cfg_rate_log2;
  logic              in_valid;
  logic [CH*W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH*OW-1:0]  out_data;
  logic              ovf;
  logic [CH*W-1:0]   in_data1;
  logic              out_valid1;
  logic [CH*OW-1:0]  out_data1;
  logic              ovf1;

  int n_tests = 0;
  int n_fail  = 0;
  int nb;
  bit ok;

  cic_decimator_mc u_dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_load      (cfg_load),
    .cfg_rate_log2 (cfg_rate_log2),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .ovf           (ovf)
  );

  cic_decimator_mc #(.N(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .cfg_load      (cfg_load),
    .cfg_rate_log2 (cfg_rate_log2),
    .in_valid      (in_valid),
    .in_data       (in_data1),
    .out_valid     (out_valid1),
    .out_ready     (out_ready),
    .out_data      (out_data1),
    .ovf           (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lane(input logic [CH*OW-1:0] d, input int c);
    return int'(signed'(d[c*OW +: OW]));
  endfunction

  task automatic set_all(input int v);
    in_data = {CH{16'(v)}};
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] r, input bit with_beat);
    cfg_rate_log2 = r;
    cfg_load      = 1'b1;
    in_valid      = with_beat;
    @(negedge clk);
    cfg_load      = 1'b0;
    in_valid      = 1'b0;
  endtask

  // Feed beats until out_valid is seen, at most maxb beats; nb is the beat count.
  task automatic wait_out(input int maxb, output int cnt, output bit seen);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < maxb) begin
      in_valid = 1'b1;
      @(negedge clk);
      cnt++;
      seen = out_valid;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_rate_log2 = 3'd1; in_valid = 1'b0;
    in_data = '0; in_data1 = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld", int'(out_valid), 0);
    check("rst_dat", lane(out_data, 0), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    // DC gain at R=8
    load(3'd3, 1'b0);
    set_all(1000);
    feed(80);
    wait_out(16, nb, ok);
    check("dc_seen", int'(ok), 1);
    for (int c = 0; c < CH; c++) check($sformatf("dc_ch%0d", c), lane(out_data, c), 1000);
    check("dc_ovf", int'(ovf), 0);

    // Independent channels
    load(3'd3, 1'b0);
    in_data = {16'(32767), 16'(0), 16'(-2000), 16'(2000)};
    feed(80);
    wait_out(16, nb, ok);
    check("pc_seen", int'(ok), 1);
    check("pc_ch0", lane(out_data, 0), 2000);
    check("pc_ch1", lane(out_data, 1), -2000);
    check("pc_ch2", lane(out_data, 2), 0);
    check("pc_ch3", lane(out_data, 3), 32767);

    // Rate change drops the pending sample; the beat alongside cfg_load is discarded
    load(3'd2, 1'b0);
    set_all(500);
    out_ready = 1'b0;
    feed(4);
    check("rc_pend_vld", int'(out_valid), 1);
    feed(4);
    check("rc_ovf_set", int'(ovf), 1);
    load(3'd5, 1'b1);
    check("rc_drop_vld", int'(out_valid), 0);
    check("rc_ovf_clr", int'(ovf), 0);
    out_ready = 1'b1;
    wait_out(64, nb, ok);
    check("rc_first_beats", nb, 32);
    feed(128);
    wait_out(40, nb, ok);
    check("rc_seen", int'(ok), 1);
    check("rc_ch0", lane(out_data, 0), 500);
    check("rc_ch3", lane(out_data, 3), 500);

    // Clamping: 7 -> 6, 0 -> 1
    load(3'd7, 1'b0);
    wait_out(100, nb, ok);
    check("clamp_hi_beats", nb, 64);
    feed(256);
    wait_out(70, nb, ok);
    check("clamp_hi_ch1", lane(out_data, 1), 500);
    load(3'd0, 1'b0);
    wait_out(8, nb, ok);
    check("clamp_lo_beats", nb, 2);

    // Transfer and new load in the same cycle is not an overrun (R=2, step 16)
    load(3'd1, 1'b0);
    set_all(16);
    out_ready = 1'b0;
    feed(3);
    check("xl_pre_vld", int'(out_valid), 1);
    out_ready = 1'b1;
    feed(1);
    check("xl_vld", int'(out_valid), 1);
    check("xl_ovf", int'(ovf), 0);
    check("xl_dat", lane(out_data, 0), 8);

    // Overrun across two decimation beats (R=4, step 16: samples 1 then 11)
    load(3'd2, 1'b0);
    out_ready = 1'b0;
    feed(4);
    check("bp_first_dat", lane(out_data, 0), 1);
    check("bp_first_ovf", int'(ovf), 0);
    feed(4);
    check("bp_ovf", int'(ovf), 1);
    check("bp_second_dat", lane(out_data, 2), 11);
    repeat (2) @(negedge clk);
    check("bp_hold_dat", lane(out_data, 0), 11);
    check("bp_hold_vld", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_vld", int'(out_valid), 0);
    check("bp_ovf_sticky", int'(ovf), 1);
    load(3'd1, 1'b0);
    check("bp_ovf_clr", int'(ovf), 0);

    // Reset mid-operation: R=8, 13 beats leaves cnt=5 with an unaccepted sample
    load(3'd3, 1'b0);
    set_all(1000);
    out_ready = 1'b0;
    feed(13);
    check("rm_pre_vld", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_vld", int'(out_valid), 0);
    check("rm_dat", lane(out_data, 0), 0);
    check("rm_ovf", int'(ovf), 0);
    out_ready = 1'b1;
    wait_out(20, nb, ok);
    check("rm_first_beats", nb, 2);

    // Rounding on the N=1 instance: impulse of 1 at R=2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load(3'd1, 1'b0);
    set_all(0);
    in_data1 = {CH{16'd1}};
    feed(1);
    in_data1 = '0;
    feed(1);
    check("rnd_vld", int'(out_valid1), 1);
    check("rnd_ch0", lane(out_data1, 0), RND_EXP);
    check("rnd_ch3", lane(out_data1, 3), RND_EXP);
    feed(2);
    check("rnd_second", lane(out_data1, 0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
